vx_secded_pipe: RTL
===================

// Module: vx_secded_pipe
// PURPOSE
//  Multi-lane, pipelined SECDED Hamming codec (encode or decode, selected per transaction) with a valid/ready handshake.
//  Sits between cache data arrays and the bank datapath. Corrects single-bit errors and flags double-bit errors.
//  Keeps saturating error counters and supports one-shot error injection for fault testing.
//  Codeword layout per lane:
//   - check bit p sits at index 2**p-1;
//   - data bits fill the remaining indices of [ENC-2:0], LSB first;
//   - bit ENC-1 = XOR of bits [ENC-2:0].
// PARAMETERS
//  DATA_BITS     128  data bits per lane
//  NUM_LANES     1    independent lanes sharing one handshake
//  PIPE_REG      0    0: latency 1; 1: extra middle register, latency 2
//  CNT_BITS      16   width of each error counter
//  HAM_BITS      derived: smallest r with 2**r >= DATA_BITS+r+1 (8 for 128)
//  ENC           derived: DATA_BITS+HAM_BITS+1
// PORTS
//  clk          in   1              clock
//  reset        in   1              asynchronous, active-high reset
//  in_valid     in   1              input transaction valid
//  in_ready     out  1              block can accept input
//  in_decode    in   1              0 = encode, 1 = decode
//  in_data      in   NUM_LANES*ENC  per-lane slot; encode uses slot bits [DATA_BITS-1:0], rest ignored
//  out_valid    out  1              result valid
//  out_ready    in   1              consumer accepts result
//  out_data     out  NUM_LANES*ENC  encode: codeword; decode: corrected data, zero-extended to ENC
//  out_sec      out  NUM_LANES      decode: single error corrected
//  out_ded      out  NUM_LANES      decode: uncorrectable error detected
//  out_syndrome out  NUM_LANES*HAM_BITS  decode syndrome (0 in encode)
//  inj_arm      in   1              pulse: arm one-shot injection
//  inj_lane     in   clog2(LANES)   lane to corrupt (sampled on arm)
//  inj_bit      in   clog2(ENC)     bit index to flip (sampled on arm)
//  inj_pending  out  1              injection armed, not yet consumed
//  cnt_clr      in   1              clear both counters
//  sec_count    out  CNT_BITS       total corrected errors, saturating
//  ded_count    out  CNT_BITS       total uncorrectable errors, saturating
// BEHAVIOUR
//  Reset values: all outputs 0 (out_valid, flags, data, counters, inj_pending); in_ready = 1 after reset.
//  Handshake:
//   - transfer on valid&ready at either port;
//   - each stage register loads when empty or when downstream accepts;
//   - in_ready = !stage_full[0] | stage_ready[0]; full throughput with out_ready held high;
//   - out_* stay stable while out_valid & !out_ready.
//  Encode:
//   - check bit p = XOR of codeword bits at 1-based positions c with bit p of c set;
//   - then the overall parity bit is set; sec/ded/syndrome = 0.
//  Injection:
//   - applies to the first encode accepted after arm: flip bit inj_bit of lane inj_lane's codeword;
//   - inj_pending clears on that acceptance;
//   - re-arm while pending overwrites lane/bit;
//   - inj_bit >= ENC: pending consumed, no flip;
//   - decode transactions never consume injection.
//  Decode, per lane: s = syndrome over [ENC-2:0], q = XOR of all ENC bits.
//   - s=0, q=0: clean.
//   - q=1, s=0: parity bit flipped; sec=1, data unchanged.
//   - q=1, 1 <= s <= ENC-1: flip bit s-1, sec=1.
//   - q=1, s > ENC-1: ded=1.
//   - s!=0, q=0: ded=1, data passed uncorrected.
//  Counters:
//   - add popcount(out_sec) / popcount(out_ded) on each output transfer;
//   - saturate at all-ones;
//   - cnt_clr has priority over same-cycle increments.
//  Reset mid-operation: pipeline contents, pending injection and counters are discarded immediately.
// TESTING (DATA_BITS=8, NUM_LANES=1 unless noted; ENC=13, codeword of 8'hA5 = 13'h0A27)
//  1. encode 8'hA5 -> out_data 13'h0A27, flags 0; decode 13'h0A27 -> 8'hA5, sec=ded=0, syndrome 0
//  2. decode 13'h0A07 (bit5 flipped) -> data 8'hA5, sec=1, syndrome 6; sec_count 1
//  3. decode 13'h0A06 (bits 5, 0) -> ded=1, sec=0; decode 13'h1A27 -> 8'hA5, sec=1, syndrome 0
//  4. inj_arm lane0 bit5, then encode 8'hA5 -> 13'h0A07, inj_pending 1->0; next encode -> 13'h0A27
//  5. PIPE_REG=1, 4 back-to-back transactions, out_ready low 3 cycles -> in_ready drops when full; order and data preserved
//  6. CNT_BITS=2: 5 sec errors -> sec_count 3; cnt_clr with same-cycle error -> 0

Source files
------------

// File: rtl/vx_secded_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vx_secded_pipe_if : handshake and data bus of the SECDED codec    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface vx_secded_pipe_if #(
  parameter int DATA_BITS = 128,
  parameter int NUM_LANES = 1
);
  localparam int HAM_BITS = $clog2(DATA_BITS + 1 + $clog2(DATA_BITS + 1));
  localparam int ENC      = DATA_BITS + HAM_BITS + 1;

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_decode;
  logic [NUM_LANES*ENC-1:0]      in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_LANES*ENC-1:0]      out_data;
  logic [NUM_LANES-1:0]          out_sec;
  logic [NUM_LANES-1:0]          out_ded;
  logic [NUM_LANES*HAM_BITS-1:0] out_syndrome;

  modport master (
    output in_valid, in_decode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sec, out_ded, out_syndrome
  );

  modport slave (
    input  in_valid, in_decode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sec, out_ded, out_syndrome
  );
endinterface
`default_nettype wire

// File: rtl/vx_secded_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vx_secded_pipe : multi-lane pipelined SECDED encoder/decoder      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vx_secded_pipe #(
  parameter int  DATA_BITS = 128,
  parameter int  NUM_LANES = 1,
  parameter int  PIPE_REG  = 0,
  parameter int  CNT_BITS  = 16,
  localparam int HAM_BITS  = $clog2(DATA_BITS + 1 + $clog2(DATA_BITS + 1)),
  localparam int ENC       = DATA_BITS + HAM_BITS + 1,
  localparam int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int BIT_W     = $clog2(ENC)
) (
  input  wire logic                clk,
  input  wire logic                reset,
  vx_secded_pipe_if.slave          bus,
  input  wire logic                inj_arm,
  input  wire logic [LANE_W-1:0]   inj_lane,
  input  wire logic [BIT_W-1:0]    inj_bit,
  output logic                     inj_pending,
  input  wire logic                cnt_clr,
  output logic [CNT_BITS-1:0]      sec_count,
  output logic [CNT_BITS-1:0]      ded_count
);

  function automatic logic [ENC-1:0] f_encode(input logic [DATA_BITS-1:0] d);
    logic [ENC-1:0]       cw;
    logic [DATA_BITS-1:0] sh;
    logic                 par;
    cw = '0;
    sh = d;
    for (int i = 0; i < ENC - 1; i++) begin
      if (((i + 1) & i) != 0) begin
        cw[i] = sh[0];
        sh    = sh >> 1;
      end
    end
    for (int p = 0; p < HAM_BITS; p++) begin
      par = 1'b0;
      for (int i = 0; i < ENC - 1; i++)
        if ((((i + 1) >> p) & 1) != 0) par = par ^ cw[i];
      for (int i = 0; i < ENC - 1; i++)
        if ((i + 1) == (1 << p)) cw[i] = par;
    end
    cw[ENC-1] = ^cw[ENC-2:0];
    return cw;
  endfunction

  function automatic logic [HAM_BITS-1:0] f_syndrome(input logic [ENC-1:0] cw);
    logic [HAM_BITS-1:0] s;
    s = '0;
    for (int i = 0; i < ENC - 1; i++)
      if (cw[i]) s = s ^ HAM_BITS'(i + 1);
    return s;
  endfunction

  // Data sits at non-power-of-two positions; shift in from the top so the first ends at bit 0.
  function automatic logic [DATA_BITS-1:0] f_extract(input logic [ENC-1:0] cw);
    logic [DATA_BITS-1:0] d;
    d = '0;
    for (int i = 0; i < ENC - 1; i++)
      if (((i + 1) & i) != 0) d = (d >> 1) | (DATA_BITS'(cw[i]) << (DATA_BITS - 1));
    return d;
  endfunction

  function automatic logic [CNT_BITS-1:0] f_sat_add(input logic [CNT_BITS-1:0] c, input int n);
    logic [CNT_BITS:0] s;
    s = {1'b0, c} + (CNT_BITS + 1)'(n);
    return s[CNT_BITS] ? {CNT_BITS{1'b1}} : s[CNT_BITS-1:0];
  endfunction

  logic                          r_inj_pending;
  logic [LANE_W-1:0]             r_inj_lane;
  logic [BIT_W-1:0]              r_inj_bit;
  logic [NUM_LANES*ENC-1:0]      w_res_data;
  logic [NUM_LANES-1:0]          w_res_sec;
  logic [NUM_LANES-1:0]          w_res_ded;
  logic [NUM_LANES*HAM_BITS-1:0] w_res_syn;

  genvar gl;
  generate
    for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
      logic [ENC-1:0]      w_in_cw;
      logic [ENC-1:0]      w_enc_cw;
      logic [ENC-1:0]      w_fix_cw;
      logic [ENC-1:0]      w_inj_mask;
      logic [HAM_BITS-1:0] w_syn;
      logic                w_q;
      logic                w_sec;
      logic                w_ded;

      assign w_in_cw    = bus.in_data[gl*ENC +: ENC];
      // Bit indices at or beyond ENC shift out of the mask, so they consume without flipping.
      assign w_inj_mask = (r_inj_pending && (NUM_LANES == 1 || int'(r_inj_lane) == gl))
                          ? (ENC'(1) << r_inj_bit) : '0;
      assign w_enc_cw   = f_encode(w_in_cw[DATA_BITS-1:0]) ^ w_inj_mask;
      assign w_syn      = f_syndrome(w_in_cw);
      assign w_q        = ^w_in_cw;

      always_comb begin
        w_fix_cw = w_in_cw;
        w_sec    = 1'b0;
        w_ded    = 1'b0;
        if (w_q) begin
          if (int'(w_syn) <= ENC - 1) begin
            w_sec = 1'b1;
            for (int i = 0; i < ENC - 1; i++)
              if (int'(w_syn) == i + 1) w_fix_cw[i] = ~w_fix_cw[i];
          end else begin
            w_ded = 1'b1;
          end
        end else if (w_syn != '0) begin
          w_ded = 1'b1;
        end
      end

      assign w_res_data[gl*ENC +: ENC]           = bus.in_decode ? ENC'(f_extract(w_fix_cw)) : w_enc_cw;
      assign w_res_sec[gl]                       = bus.in_decode & w_sec;
      assign w_res_ded[gl]                       = bus.in_decode & w_ded;
      assign w_res_syn[gl*HAM_BITS +: HAM_BITS]  = bus.in_decode ? w_syn : '0;
    end
  endgenerate

  logic                          r_s0_full;
  logic [NUM_LANES*ENC-1:0]      r_s0_data;
  logic [NUM_LANES-1:0]          r_s0_sec;
  logic [NUM_LANES-1:0]          r_s0_ded;
  logic [NUM_LANES*HAM_BITS-1:0] r_s0_syn;
  logic                          w_s0_ready;
  logic                          w_in_ready;
  logic                          w_in_fire;
  logic                          w_out_valid;
  logic [NUM_LANES*ENC-1:0]      w_out_data;
  logic [NUM_LANES-1:0]          w_out_sec;
  logic [NUM_LANES-1:0]          w_out_ded;
  logic [NUM_LANES*HAM_BITS-1:0] w_out_syn;
  logic                          w_out_fire;

  assign w_in_ready = !r_s0_full | w_s0_ready;
  assign w_in_fire  = bus.in_valid & w_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s0_full <= 1'b0;
      r_s0_data <= '0;
      r_s0_sec  <= '0;
      r_s0_ded  <= '0;
      r_s0_syn  <= '0;
    end else if (w_in_ready) begin
      r_s0_full <= bus.in_valid;
      if (bus.in_valid) begin
        r_s0_data <= w_res_data;
        r_s0_sec  <= w_res_sec;
        r_s0_ded  <= w_res_ded;
        r_s0_syn  <= w_res_syn;
      end
    end
  end

  generate
    if (PIPE_REG != 0) begin : g_mid
      logic                          r_s1_full;
      logic [NUM_LANES*ENC-1:0]      r_s1_data;
      logic [NUM_LANES-1:0]          r_s1_sec;
      logic [NUM_LANES-1:0]          r_s1_ded;
      logic [NUM_LANES*HAM_BITS-1:0] r_s1_syn;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s1_full <= 1'b0;
          r_s1_data <= '0;
          r_s1_sec  <= '0;
          r_s1_ded  <= '0;
          r_s1_syn  <= '0;
        end else if (!r_s1_full || bus.out_ready) begin
          r_s1_full <= r_s0_full;
          if (r_s0_full) begin
            r_s1_data <= r_s0_data;
            r_s1_sec  <= r_s0_sec;
            r_s1_ded  <= r_s0_ded;
            r_s1_syn  <= r_s0_syn;
          end
        end
      end

      assign w_s0_ready  = !r_s1_full | bus.out_ready;
      assign w_out_valid = r_s1_full;
      assign w_out_data  = r_s1_data;
      assign w_out_sec   = r_s1_sec;
      assign w_out_ded   = r_s1_ded;
      assign w_out_syn   = r_s1_syn;
    end else begin : g_direct
      assign w_s0_ready  = bus.out_ready;
      assign w_out_valid = r_s0_full;
      assign w_out_data  = r_s0_data;
      assign w_out_sec   = r_s0_sec;
      assign w_out_ded   = r_s0_ded;
      assign w_out_syn   = r_s0_syn;
    end
  endgenerate

  assign w_out_fire       = w_out_valid & bus.out_ready;
  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_data     = w_out_data;
  assign bus.out_sec      = w_out_sec;
  assign bus.out_ded      = w_out_ded;
  assign bus.out_syndrome = w_out_syn;

  // A same-cycle arm wins over consumption: the accepted encode uses the old target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inj_pending <= 1'b0;
      r_inj_lane    <= '0;
      r_inj_bit     <= '0;
    end else if (inj_arm) begin
      r_inj_pending <= 1'b1;
      r_inj_lane    <= inj_lane;
      r_inj_bit     <= inj_bit;
    end else if (w_in_fire && !bus.in_decode) begin
      r_inj_pending <= 1'b0;
    end
  end

  assign inj_pending = r_inj_pending;

  logic [CNT_BITS-1:0] r_sec_cnt;
  logic [CNT_BITS-1:0] r_ded_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (cnt_clr) begin
      r_sec_cnt <= '0;
      r_ded_cnt <= '0;
    end else if (w_out_fire) begin
      r_sec_cnt <= f_sat_add(r_sec_cnt, $countones(w_out_sec));
      r_ded_cnt <= f_sat_add(r_ded_cnt, $countones(w_out_ded));
    end
  end

  assign sec_count = r_sec_cnt;
  assign ded_count = r_ded_cnt;

endmodule
`default_nettype wire
